// File: rtl/data_bank_param_if.sv
// Operand bank bus: write port, two read-select ports and the bulk-clear control,
// grouped so the decoder side and the bank side share one bundle.
interface data_bank_param_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          cen;
    logic          we;
    logic [AW-1:0] rd_i;
    logic [DW-1:0] dat_i;
    logic [AW-1:0] rs_i;
    logic [AW-1:0] rs2_i;
    logic          clr_i;
    logic [DW-1:0] rs_o;
    logic [DW-1:0] rs2_o;
    logic          busy_o;
    logic          oor_o;

    modport master (
        output cen, we, rd_i, dat_i, rs_i, rs2_i, clr_i,
        input  rs_o, rs2_o, busy_o, oor_o
    );

    modport slave (
        input  cen, we, rd_i, dat_i, rs_i, rs2_i, clr_i,
        output rs_o, rs2_o, busy_o, oor_o
    );
endinterface

// File: rtl/data_bank_param.sv
// Parametrised two-read/one-write register bank with registered read ports,
// write-first bypass, optional zero entry 0, range checking and a bulk-clear sweep.
module data_bank_param #(
    parameter int DW      = 8,
    parameter int DEPTH   = 8,
    parameter bit ZERO_R0 = 1'b0
) (
    input logic              clk,
    input logic              rst,
    data_bank_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [DW-1:0] mem [DEPTH];
    logic          wr_ok;
    logic          oor_n;
    logic [DW-1:0] rs_n, rs2_n;

    // DEPTH need not be a power of two, so encodable addresses can lie past the last entry.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic [DW-1:0] value(input logic [AW-1:0] a,
                                            input logic          acc,
                                            input logic [AW-1:0] wa,
                                            input logic [DW-1:0] wd);
        if (!in_range(a) || (ZERO_R0 && a == '0)) return '0;
        if (acc && a == wa) return wd;
        return mem[a];
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_n = state;
        cnt_n   = cnt;
        wr_ok   = 1'b0;
        oor_n   = 1'b0;
        rs_n    = '0;
        rs2_n   = '0;
        case (state)
            IDLE: begin
                wr_ok = bus.we && !bus.clr_i && in_range(bus.rd_i) &&
                        !(ZERO_R0 && bus.rd_i == '0);
                rs_n  = value(bus.rs_i,  wr_ok, bus.rd_i, bus.dat_i);
                rs2_n = value(bus.rs2_i, wr_ok, bus.rd_i, bus.dat_i);
                oor_n = !in_range(bus.rs_i) || !in_range(bus.rs2_i) ||
                        (bus.we && !in_range(bus.rd_i));
                if (bus.clr_i) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            CLEAR: begin
                if (32'(cnt) == DEPTH - 1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + AW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.rs_o  <= '0;
            bus.rs2_o <= '0;
            bus.oor_o <= 1'b0;
            // NOTE: the array is flop-based and must come out of reset all-zero, so it is reset too.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.cen) begin
            state     <= state_n;
            cnt       <= cnt_n;
            bus.rs_o  <= rs_n;
            bus.rs2_o <= rs2_n;
            bus.oor_o <= oor_n;
            if (state == CLEAR) mem[cnt] <= '0;
            else if (wr_ok)     mem[bus.rd_i] <= bus.dat_i;
        end
    end

    // Busy is exactly the time spent in the sweep state, DEPTH enabled cycles per clear.
    assign bus.busy_o = (state == CLEAR);
endmodule

// File: tb/tb_data_bank_param.sv
// Self-checking bench: two bank instances (8-deep plain, 6-deep with zero entry 0)
// against a behavioural model, directed scenarios then randomized traffic.
module tb_data_bank_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_bank_param_if #(.DW(8), .DEPTH(8)) bus8();
    data_bank_param_if #(.DW(8), .DEPTH(6)) bus6();

    data_bank_param #(.DW(8), .DEPTH(8), .ZERO_R0(1'b0)) u_dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );
    data_bank_param #(.DW(8), .DEPTH(6), .ZERO_R0(1'b1)) u_dut6 (
        .clk(clk), .rst(rst), .bus(bus6)
    );

    int errors = 0;
    int checks = 0;

    // Reference model, index 0 = 8-deep bank, index 1 = 6-deep bank with zero entry 0.
    int         depth [2] = '{8, 6};
    bit         zr    [2] = '{1'b0, 1'b1};
    logic [7:0] mm    [2][8];
    int         sweep [2];
    logic [7:0] e_rs  [2];
    logic [7:0] e_rs2 [2];
    logic       e_oor [2];

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) mm[s][i] = 8'h00;
            sweep[s] = -1;
            e_rs[s]  = 8'h00;
            e_rs2[s] = 8'h00;
            e_oor[s] = 1'b0;
        end
    endfunction

    function automatic logic [7:0] mval(int s, int a, bit acc, int rd, logic [7:0] dat);
        if (a >= depth[s]) return 8'h00;
        if (zr[s] && a == 0) return 8'h00;
        if (acc && a == rd) return dat;
        return mm[s][a];
    endfunction

    function automatic void model_edge(int s, bit we, int rd, logic [7:0] dat,
                                       int rs, int rs2, bit clr);
        bit acc;
        if (sweep[s] >= 0) begin
            mm[s][sweep[s]] = 8'h00;
            e_rs[s]  = 8'h00;
            e_rs2[s] = 8'h00;
            e_oor[s] = 1'b0;
            sweep[s]++;
            if (sweep[s] == depth[s]) sweep[s] = -1;
        end else begin
            acc = we && rd < depth[s] && !(zr[s] && rd == 0) && !clr;
            e_rs[s]  = mval(s, rs,  acc, rd, dat);
            e_rs2[s] = mval(s, rs2, acc, rd, dat);
            e_oor[s] = (rs >= depth[s]) || (rs2 >= depth[s]) || (we && rd >= depth[s]);
            if (acc) mm[s][rd] = dat;
            if (clr) sweep[s] = 0;
        end
    endfunction

    function automatic logic [17:0] act(int s);
        if (s == 0) return {bus8.rs_o, bus8.rs2_o, bus8.busy_o, bus8.oor_o};
        return {bus6.rs_o, bus6.rs2_o, bus6.busy_o, bus6.oor_o};
    endfunction

    function automatic logic [17:0] expv(int s);
        return {e_rs[s], e_rs2[s], (sweep[s] >= 0), e_oor[s]};
    endfunction

    task automatic set_bus(int s, bit cen, bit we, int rd, logic [7:0] dat,
                           int rs, int rs2, bit clr);
        if (s == 0) begin
            bus8.cen = cen; bus8.we = we; bus8.rd_i = 3'(rd); bus8.dat_i = dat;
            bus8.rs_i = 3'(rs); bus8.rs2_i = 3'(rs2); bus8.clr_i = clr;
        end else begin
            bus6.cen = cen; bus6.we = we; bus6.rd_i = 3'(rd); bus6.dat_i = dat;
            bus6.rs_i = 3'(rs); bus6.rs2_i = 3'(rs2); bus6.clr_i = clr;
        end
    endtask

    // One clock on bank s; the other bank sees random inputs with cen=0 and must hold.
    task automatic step(int s, bit cen, bit we, int rd, logic [7:0] dat,
                        int rs, int rs2, bit clr);
        set_bus(1 - s, 1'b0, 1'($urandom), int'($urandom % 8), 8'($urandom),
                int'($urandom % 8), int'($urandom % 8), 1'($urandom));
        set_bus(s, cen, we, rd, dat, rs, rs2, clr);
        @(posedge clk);
        if (cen) model_edge(s, we, rd, dat, rs, rs2, clr);
        #1;
    endtask

    task automatic test_reset();
        set_bus(0, 1'b0, 1'b0, 0, 8'h00, 0, 0, 1'b0);
        set_bus(1, 1'b0, 1'b0, 0, 8'h00, 0, 0, 1'b0);
        rst = 1'b0;
        model_reset();
        #3;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (act(s) !== 18'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %h want %h", s, act(s), 18'h0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        step(0, 1'b1, 1'b1, 0, 8'hFF, 1, 2, 1'b0);
        checks++;
        if ({bus8.rs_o, bus8.rs2_o} !== 16'h0000) begin
            errors++;
            $display("FAIL unwritten_read: got %h want %h", {bus8.rs_o, bus8.rs2_o}, 16'h0000);
        end
        step(0, 1'b1, 1'b1, 1, 8'hFE, 0, 0, 1'b0);
        step(0, 1'b1, 1'b1, 2, 8'hAA, 0, 0, 1'b0);
        step(0, 1'b1, 1'b0, 0, 8'h00, 1, 2, 1'b0);
        checks++;
        if ({bus8.rs_o, bus8.rs2_o} !== 16'hFEAA) begin
            errors++;
            $display("FAIL read_1_2: got %h want %h", {bus8.rs_o, bus8.rs2_o}, 16'hFEAA);
        end
        step(0, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b0);
        checks++;
        if (bus8.rs_o !== 8'hFF) begin
            errors++;
            $display("FAIL read_0: got %h want %h", bus8.rs_o, 8'hFF);
        end
    endtask

    task automatic test_bypass();
        step(0, 1'b1, 1'b1, 3, 8'h5A, 3, 3, 1'b0);
        checks++;
        if ({bus8.rs_o, bus8.rs2_o} !== 16'h5A5A) begin
            errors++;
            $display("FAIL bypass: got %h want %h", {bus8.rs_o, bus8.rs2_o}, 16'h5A5A);
        end
        step(0, 1'b1, 1'b0, 0, 8'h00, 3, 0, 1'b0);
        checks++;
        if (bus8.rs_o !== 8'h5A) begin
            errors++;
            $display("FAIL bypass_after: got %h want %h", bus8.rs_o, 8'h5A);
        end
    endtask

    task automatic test_cen_hold();
        step(0, 1'b1, 1'b0, 0, 8'h00, 3, 3, 1'b0);
        step(0, 1'b0, 1'b1, 4, 8'h77, 4, 4, 1'b0);
        checks++;
        if ({bus8.rs_o, bus8.rs2_o} !== 16'h5A5A) begin
            errors++;
            $display("FAIL cen_hold_out: got %h want %h", {bus8.rs_o, bus8.rs2_o}, 16'h5A5A);
        end
        step(0, 1'b1, 1'b0, 0, 8'h00, 4, 3, 1'b0);
        checks++;
        if ({bus8.rs_o, bus8.rs2_o} !== 16'h005A) begin
            errors++;
            $display("FAIL cen_hold_mem: got %h want %h", {bus8.rs_o, bus8.rs2_o}, 16'h005A);
        end
    endtask

    task automatic test_zero_oor();
        step(1, 1'b1, 1'b1, 0, 8'h33, 0, 0, 1'b0);
        step(1, 1'b1, 1'b1, 5, 8'h44, 0, 5, 1'b0);
        checks++;
        if ({bus6.rs_o, bus6.rs2_o, bus6.oor_o} !== {8'h00, 8'h44, 1'b0}) begin
            errors++;
            $display("FAIL zero_r0_read: got %h want %h",
                     {bus6.rs_o, bus6.rs2_o, bus6.oor_o}, {8'h00, 8'h44, 1'b0});
        end
        step(1, 1'b1, 1'b0, 0, 8'h00, 7, 5, 1'b0);
        checks++;
        if ({bus6.rs_o, bus6.oor_o} !== {8'h00, 1'b1}) begin
            errors++;
            $display("FAIL oor_read: got %h want %h", {bus6.rs_o, bus6.oor_o}, {8'h00, 1'b1});
        end
        step(1, 1'b1, 1'b0, 0, 8'h00, 5, 5, 1'b0);
        checks++;
        if (bus6.oor_o !== 1'b0) begin
            errors++;
            $display("FAIL oor_pulse: got %b want %b", bus6.oor_o, 1'b0);
        end
        step(1, 1'b1, 1'b1, 6, 8'hAB, 5, 1, 1'b0);
        checks++;
        if ({bus6.rs_o, bus6.oor_o} !== {8'h44, 1'b1}) begin
            errors++;
            $display("FAIL oor_write: got %h want %h", {bus6.rs_o, bus6.oor_o}, {8'h44, 1'b1});
        end
    endtask

    task automatic test_bulk_clear();
        int busy_cnt;
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b1, i, 8'(8'h10 + i), 0, 0, 1'b0);
        step(0, 1'b1, 1'b1, 5, 8'hEE, 7, 0, 1'b1);
        checks++;
        if ({bus8.rs_o, bus8.rs2_o, bus8.busy_o} !== {8'h17, 8'h10, 1'b1}) begin
            errors++;
            $display("FAIL clr_start: got %h want %h",
                     {bus8.rs_o, bus8.rs2_o, bus8.busy_o}, {8'h17, 8'h10, 1'b1});
        end
        busy_cnt = 1;
        for (int j = 0; j < 20; j++) begin
            step(0, 1'b1, 1'b1, int'($urandom % 8), 8'($urandom),
                 int'($urandom % 8), int'($urandom % 8), 1'b0);
            checks++;
            if ({bus8.rs_o, bus8.rs2_o} !== 16'h0000) begin
                errors++;
                $display("FAIL sweep_out: got %h want %h", {bus8.rs_o, bus8.rs2_o}, 16'h0000);
            end
            if (bus8.busy_o !== 1'b1) break;
            busy_cnt++;
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL busy_len: got %0d want %0d", busy_cnt, 8);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b1, 1'b0, 0, 8'h00, i, 7 - i, 1'b0);
            checks++;
            if ({bus8.rs_o, bus8.rs2_o} !== 16'h0000) begin
                errors++;
                $display("FAIL post_clear[%0d]: got %h want %h", i,
                         {bus8.rs_o, bus8.rs2_o}, 16'h0000);
            end
        end
        step(0, 1'b1, 1'b1, 5, 8'h99, 0, 0, 1'b0);
        step(0, 1'b1, 1'b0, 0, 8'h00, 5, 0, 1'b0);
        checks++;
        if (bus8.rs_o !== 8'h99) begin
            errors++;
            $display("FAIL write_after_clear: got %h want %h", bus8.rs_o, 8'h99);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cnt;
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b1, i, 8'(8'hC0 + i), 0, 0, 1'b0);
        step(0, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b1);
        for (int j = 0; j < 3; j++) step(0, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus8.busy_o, bus8.rs_o, bus8.rs2_o} !== 17'h0) begin
            errors++;
            $display("FAIL reset_mid_sweep: got %h want %h",
                     {bus8.busy_o, bus8.rs_o, bus8.rs2_o}, 17'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i += 2) begin
            step(0, 1'b1, 1'b0, 0, 8'h00, i, i + 1, 1'b0);
            checks++;
            if ({bus8.rs_o, bus8.rs2_o, bus8.busy_o} !== 17'h0) begin
                errors++;
                $display("FAIL reset_cleared[%0d]: got %h want %h", i,
                         {bus8.rs_o, bus8.rs2_o, bus8.busy_o}, 17'h0);
            end
        end
        // Sweep paused for two cycles with cen low: busy must stretch to DEPTH+2 cycles.
        step(0, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b1);
        busy_cnt = 1;
        for (int j = 0; j < 20; j++) begin
            step(0, !(j == 2 || j == 3), 1'b1, int'($urandom % 8), 8'($urandom),
                 int'($urandom % 8), int'($urandom % 8), 1'b0);
            if (bus8.busy_o !== 1'b1) break;
            busy_cnt++;
        end
        checks++;
        if (busy_cnt != 10) begin
            errors++;
            $display("FAIL busy_paused_len: got %0d want %0d", busy_cnt, 10);
        end
    endtask

    task automatic test_random();
        int s;
        for (int n = 0; n < 400; n++) begin
            s = int'($urandom % 2);
            step(s, ($urandom % 8) != 0, 1'($urandom), int'($urandom % 8), 8'($urandom),
                 int'($urandom % 8), int'($urandom % 8), ($urandom % 24) == 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL random[%0d] bank%0d: got %h want %h", n, k, act(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_cen_hold();
        test_zero_oor();
        test_bulk_clear();
        test_reset_mid_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/data_bank_param.md
Name: data_bank_param

Overview:
Parametrised successor to the 8x8 two-read/one-write register bank. It generalises data width and depth and adds several new behaviours: registered read ports, a write-first bypass, an optional hardwired-zero entry 0, out-of-range address handling, and a sequential bulk-clear engine with a busy flag. It sits between the instruction decoder (register selects) and the ALU operand inputs.

Parameters:
DW, 8, data width in bits (>=1).
DEPTH, 8, number of entries (>=2; need not be a power of two).
ZERO_R0, 0, 1 = entry 0 reads as 0 and writes to it are dropped.
AW (localparam), $clog2(DEPTH), address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
cen  in  1  clock enable; 0 freezes all state, outputs and FSM.
we  in  1  write enable.
rd_i  in  AW  write address.
dat_i  in  DW  write data.
rs_i  in  AW  read address, port 1.
rs2_i  in  AW  read address, port 2.
clr_i  in  1  bulk-clear request, sampled when cen=1.
rs_o  out  DW  read data, port 1 (registered).
rs2_o  out  DW  read data, port 2 (registered).
busy_o  out  1  high while the bulk clear is running.
oor_o  out  1  one-cycle pulse: an address presented this edge was >= DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries go to 0.
  - rs_o=0, rs2_o=0, busy_o=0, oor_o=0.
  - FSM goes to IDLE; clear counter goes to 0.
  - Release is sampled at the next rising edge.
- All state updates happen only on rising clk with cen=1. When cen=0, everything holds, including oor_o.
- Write (IDLE only): on an edge with we=1 and rd_i<DEPTH, entry[rd_i] <= dat_i. The write is dropped if ZERO_R0=1 and rd_i=0.
- Read latency is 1 cycle. On each cen=1 edge, rs_o <= value(rs_i) and rs2_o <= value(rs2_i).
- value(a) is resolved in this priority:
  - 0 if a>=DEPTH.
  - 0 if ZERO_R0=1 and a=0.
  - dat_i if we=1, a=rd_i and the write is accepted this edge (write-first bypass).
  - Otherwise entry[a].
- Both ports may read the same address. Both bypass independently.
- oor_o <= 1 on a cen edge when any of the following is >=DEPTH: rs_i, rs2_i, or rd_i with we=1. Otherwise oor_o <= 0. It is never asserted while in CLEAR.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a cen edge with clr_i=1. That same edge sets busy_o=1 and cnt=0. A write presented on that edge is dropped.
  - In CLEAR, each cen edge does entry[cnt] <= 0 and cnt <= cnt+1.
  - When cnt=DEPTH-1, that entry is cleared, the FSM returns to IDLE and busy_o <= 0.
  - The sweep takes DEPTH cen-cycles. busy_o is high for exactly DEPTH cen-cycles.
  - In CLEAR, we and clr_i are ignored, and rs_o/rs2_o are loaded with 0 each cen edge.
  - The first edge back in IDLE accepts writes and clr_i normally. clr_i held high re-triggers a new sweep immediately.
- Reset asserted mid-sweep aborts it: all entries are cleared, FSM goes to IDLE, busy_o=0.
- cen=0 mid-sweep pauses the counter. The sweep resumes when cen returns to 1.
- Widths: no arithmetic on data. cnt is AW bits and never exceeds DEPTH-1.

Test Plan:
- Reset then write/read (DW=8, DEPTH=8): write 0xFF@0, 0xFE@1, 0xAA@2, then read rs_i=1, rs2_i=2 -> one cycle later rs_o=0xFE, rs2_o=0xAA; values are 0 before any write.
- Bypass: we=1, rd_i=3, dat_i=0x5A, rs_i=3 on the same edge -> rs_o=0x5A after that edge; the following cycle, with we=0, still reads 0x5A.
- cen hold: cen=0 with we=1, rd_i=4, dat_i=0x77 -> entry 4 unchanged (later read = 0); rs_o holds its previous value.
- ZERO_R0=1: write 0x33@0 -> rs_o=0 on read of 0. DEPTH=6: read rs_i=7 -> rs_o=0 and oor_o=1 for one cycle; write rd_i=6 is dropped and oor_o=1.
- Bulk clear: fill entries 0..7 with 0x10..0x17, pulse clr_i -> busy_o high for exactly 8 cycles, writes during the sweep are ignored, outputs are 0; afterwards all entries read 0 and a new write 0x99@5 reads back 0x99.
- Reset mid-sweep: assert rst=0 at cnt=3 -> busy_o=0 immediately and all entries read 0. Second case: cen=0 for 2 cycles at cnt=2 -> busy_o lasts 8+2 cycles.
